// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer controller: register map, CTRL bit
// positions and counting mode/direction encodings.
package pwm_pkg;

  localparam logic [3:0] ADDR_CTRL = 4'd0;
  localparam logic [3:0] ADDR_PSC  = 4'd1;
  localparam logic [3:0] ADDR_ARR  = 4'd2;
  localparam logic [3:0] ADDR_CCER = 4'd3;
  localparam logic [3:0] ADDR_CCR0 = 4'd4;

  localparam int CTRL_CEN = 0;
  localparam int CTRL_CMS = 1;
  localparam int CTRL_PRE = 2;
  localparam int CTRL_UG  = 3;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..psc while enabled and emits a one-cycle tick
// on the terminal count.
module pwm_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] psc,
  output logic             tick
);

  logic [WIDTH-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a shrunken psc cannot strand the count above it
  always_comb begin
    tick   = enable && (pcnt_q >= psc);
    pcnt_d = pcnt_q;
    if (clear) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (enable) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timer controller: register file with preload/active shadowing,
// edge/center-aligned counter and update-event generation.
module pwm_timer_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_wdata,
  output logic [WIDTH-1:0]     cnt_value,
  output logic [NCH*WIDTH-1:0] ccr_active,
  output logic [NCH-1:0]       ch_en,
  output logic                 update_evt,
  output logic                 cnt_dir
);

  logic                 cen_q, cen_d;
  cnt_mode_e            cms_q, cms_d;
  logic                 pre_q, pre_d;
  logic [WIDTH-1:0]     psc_pre_q, psc_pre_d, psc_act_q, psc_act_d;
  logic [WIDTH-1:0]     arr_pre_q, arr_pre_d, arr_act_q, arr_act_d;
  logic [NCH-1:0]       ccer_pre_q, ccer_pre_d, ccer_act_q, ccer_act_d;
  logic [NCH*WIDTH-1:0] ccr_pre_q, ccr_pre_d, ccr_act_q, ccr_act_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  cnt_dir_e             dir_q, dir_d;
  logic                 upd_q, upd_d;

  logic wr_ctrl, ug, tick, nat_evt, upd_evt;

  assign wr_ctrl = cfg_wr && (cfg_addr == ADDR_CTRL);
  assign ug      = wr_ctrl && cfg_wdata[CTRL_UG];

  pwm_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (cen_q),
    .clear  (ug),
    .psc    (psc_act_q),
    .tick   (tick)
  );

  // Counter stepping; cnt_value above ARR (after a mode or ARR change)
  // wraps in edge mode and turns around in center mode.
  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    nat_evt = 1'b0;
    if (tick) begin
      if (arr_act_q == '0) begin
        cnt_d   = '0;
        dir_d   = DIR_UP;
        nat_evt = 1'b1;
      end else if (cms_q == MODE_EDGE) begin
        dir_d = DIR_UP;
        if (cnt_q >= arr_act_q) begin
          cnt_d   = '0;
          nat_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if ((cnt_q != '0) && ((dir_q == DIR_DOWN) || (cnt_q >= arr_act_q))) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          dir_d   = DIR_UP;
          nat_evt = 1'b1;
        end else begin
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        dir_d = (cnt_d == arr_act_q) ? DIR_DOWN : DIR_UP;
      end
    end
    if (ug) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end
  end

  assign upd_evt = nat_evt || ug;
  assign upd_d   = upd_evt;

  // The transfer is applied last so a coincident write only reaches preload.
  always_comb begin
    cen_d      = cen_q;
    cms_d      = cms_q;
    pre_d      = pre_q;
    psc_pre_d  = psc_pre_q;
    psc_act_d  = psc_act_q;
    arr_pre_d  = arr_pre_q;
    arr_act_d  = arr_act_q;
    ccer_pre_d = ccer_pre_q;
    ccer_act_d = ccer_act_q;
    ccr_pre_d  = ccr_pre_q;
    ccr_act_d  = ccr_act_q;
    if (wr_ctrl) begin
      cen_d = cfg_wdata[CTRL_CEN];
      cms_d = cnt_mode_e'(cfg_wdata[CTRL_CMS]);
      pre_d = cfg_wdata[CTRL_PRE];
    end
    if (cfg_wr && (cfg_addr == ADDR_PSC)) begin
      psc_pre_d = cfg_wdata;
      if (!pre_q) psc_act_d = cfg_wdata;
    end
    if (cfg_wr && (cfg_addr == ADDR_ARR)) begin
      arr_pre_d = cfg_wdata;
      if (!pre_q) arr_act_d = cfg_wdata;
    end
    if (cfg_wr && (cfg_addr == ADDR_CCER)) begin
      ccer_pre_d = cfg_wdata[NCH-1:0];
      if (!pre_q) ccer_act_d = cfg_wdata[NCH-1:0];
    end
    for (int i = 0; i < NCH; i++) begin
      if (cfg_wr && (cfg_addr == ADDR_CCR0 + 4'(i))) begin
        ccr_pre_d[i*WIDTH +: WIDTH] = cfg_wdata;
        if (!pre_q) ccr_act_d[i*WIDTH +: WIDTH] = cfg_wdata;
      end
    end
    if (upd_evt) begin
      psc_act_d  = psc_pre_q;
      arr_act_d  = arr_pre_q;
      ccer_act_d = ccer_pre_q;
      ccr_act_d  = ccr_pre_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_q      <= 1'b0;
      cms_q      <= MODE_EDGE;
      pre_q      <= 1'b0;
      psc_pre_q  <= '0;
      psc_act_q  <= '0;
      arr_pre_q  <= '1;
      arr_act_q  <= '1;
      ccer_pre_q <= '0;
      ccer_act_q <= '0;
      ccr_pre_q  <= '0;
      ccr_act_q  <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      upd_q      <= 1'b0;
    end else begin
      cen_q      <= cen_d;
      cms_q      <= cms_d;
      pre_q      <= pre_d;
      psc_pre_q  <= psc_pre_d;
      psc_act_q  <= psc_act_d;
      arr_pre_q  <= arr_pre_d;
      arr_act_q  <= arr_act_d;
      ccer_pre_q <= ccer_pre_d;
      ccer_act_q <= ccer_act_d;
      ccr_pre_q  <= ccr_pre_d;
      ccr_act_q  <= ccr_act_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      upd_q      <= upd_d;
    end
  end

  assign cnt_value  = cnt_q;
  assign ccr_active = ccr_act_q;
  assign ch_en      = ccer_act_q;
  assign update_evt = upd_q;
  assign cnt_dir    = (dir_q == DIR_DOWN);

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Directed bench for pwm_timer_ctrl: a cycle table for edge/center counting
// plus hand-written sequences for prescaling, preload, UG and reset.
module tb_pwm_timer_ctrl;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_wr;
  logic [3:0]           cfg_addr;
  logic [WIDTH-1:0]     cfg_wdata;
  logic [WIDTH-1:0]     cnt_value;
  logic [NCH*WIDTH-1:0] ccr_active;
  logic [NCH-1:0]       ch_en;
  logic                 update_evt;
  logic                 cnt_dir;

  int checks = 0;
  int errors = 0;

  pwm_timer_ctrl #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cnt_value  (cnt_value),
    .ccr_active (ccr_active),
    .ch_en      (ch_en),
    .update_evt (update_evt),
    .cnt_dir    (cnt_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic [3:0]       addr;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             upd;
  } vec_t;

  vec_t vecs [22];

  // Drives one cycle of inputs at a falling edge and returns at the next one,
  // so the outputs seen afterwards reflect the rising edge in between.
  task automatic applyStimulus(input logic wr, input logic [3:0] addr,
                               input logic [WIDTH-1:0] data);
    cfg_wr    = wr;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_wr    = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    cfg_wr    = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitCnt(input logic [WIDTH-1:0] val, input int budget);
    for (int i = 0; i < budget && cnt_value !== val; i++)
      applyStimulus(1'b0, 4'd0, '0);
    checkOutput("wait_cnt", 64'(cnt_value), 64'(val));
  endtask

  task automatic waitUpd(input int budget);
    for (int i = 0; i < budget && update_evt !== 1'b1; i++)
      applyStimulus(1'b0, 4'd0, '0);
    checkOutput("wait_upd", 64'(update_evt), 64'd1);
  endtask

  initial begin
    // wr, addr, data, expected cnt, dir, update_evt
    vecs[0]  = '{1'b1, 4'd2, 16'd4,   16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 16'h1,   16'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 16'd0,   16'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 16'd0,   16'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 16'd0,   16'd4, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 16'd0,   16'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 16'd0,   16'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd2, 16'd3,   16'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd0, 16'hB,   16'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 16'd0,   16'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 16'd0,   16'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'd0, 16'd0,   16'd2, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'd0, 16'd0,   16'd0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'd0, 16'd0,   16'd2, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 4'd0, 16'h1,   16'd3, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'd0, 16'd0,   16'd0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 4'd0, 16'd0,   16'd1, 1'b0, 1'b0};

    cfg_wr    = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    checkOutput("rst_cnt", 64'(cnt_value), 64'd0);
    checkOutput("rst_ccr", 64'(ccr_active), 64'd0);
    checkOutput("rst_chen", 64'(ch_en), 64'd0);
    checkOutput("rst_upd", 64'(update_evt), 64'd0);
    checkOutput("rst_dir", 64'(cnt_dir), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Edge mode ARR=4, UG into center mode ARR=3, then back to edge
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d_cnt", i), 64'(cnt_value), 64'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d_dir", i), 64'(cnt_dir), 64'(vecs[i].dir));
      checkOutput($sformatf("vec%0d_upd", i), 64'(update_evt), 64'(vecs[i].upd));
    end

    // PSC=2, ARR=3: a step every 3 cycles, an update every 12
    doReset();
    applyStimulus(1'b1, 4'd1, 16'd2);
    applyStimulus(1'b1, 4'd2, 16'd3);
    applyStimulus(1'b1, 4'd0, 16'h1);
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b0, 4'd0, '0);
      checkOutput($sformatf("psc_cnt%0d", k), 64'(cnt_value), 64'((k / 3) % 4));
      checkOutput($sformatf("psc_upd%0d", k), 64'(update_evt), (k % 12 == 0) ? 64'd1 : 64'd0);
    end

    // ARR=0 holds the counter and updates on every tick
    doReset();
    applyStimulus(1'b1, 4'd2, 16'd0);
    applyStimulus(1'b1, 4'd0, 16'h1);
    checkOutput("arr0_first", 64'(update_evt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'd0, '0);
      checkOutput("arr0_upd", 64'(update_evt), 64'd1);
      checkOutput("arr0_cnt", 64'(cnt_value), 64'd0);
    end

    // Preload: CCR0/CCER writes wait for the update event
    doReset();
    applyStimulus(1'b1, 4'd2, 16'd5);
    applyStimulus(1'b1, 4'd4, 16'd3);
    applyStimulus(1'b1, 4'd3, 16'h1);
    checkOutput("direct_ccr0", 64'(ccr_active[15:0]), 64'd3);
    checkOutput("direct_chen", 64'(ch_en), 64'd1);
    applyStimulus(1'b1, 4'd0, 16'h5);
    applyStimulus(1'b0, 4'd0, '0);
    applyStimulus(1'b0, 4'd0, '0);
    applyStimulus(1'b1, 4'd4, 16'd10);
    applyStimulus(1'b1, 4'd3, 16'h3);
    checkOutput("pre_ccr0_hold", 64'(ccr_active[15:0]), 64'd3);
    checkOutput("pre_chen_hold", 64'(ch_en), 64'd1);
    waitUpd(10);
    checkOutput("pre_ccr0_xfer", 64'(ccr_active[15:0]), 64'd10);
    checkOutput("pre_chen_xfer", 64'(ch_en), 64'd3);
    waitCnt(16'd5, 10);
    applyStimulus(1'b1, 4'd4, 16'd20);
    checkOutput("coinc_upd", 64'(update_evt), 64'd1);
    checkOutput("coinc_ccr0", 64'(ccr_active[15:0]), 64'd10);
    applyStimulus(1'b0, 4'd0, '0);
    waitUpd(10);
    checkOutput("coinc_ccr0_next", 64'(ccr_active[15:0]), 64'd20);

    // UG with the counter frozen at 7
    doReset();
    applyStimulus(1'b1, 4'd2, 16'd100);
    applyStimulus(1'b1, 4'd0, 16'h1);
    waitCnt(16'd6, 20);
    applyStimulus(1'b1, 4'd0, 16'h4);
    checkOutput("ug_frozen7", 64'(cnt_value), 64'd7);
    applyStimulus(1'b0, 4'd0, '0);
    applyStimulus(1'b1, 4'd5, 16'h55);
    checkOutput("ug_still7", 64'(cnt_value), 64'd7);
    checkOutput("ug_ccr1_hold", 64'(ccr_active[31:16]), 64'd0);
    applyStimulus(1'b1, 4'd0, 16'hC);
    checkOutput("ug_cnt", 64'(cnt_value), 64'd0);
    checkOutput("ug_upd", 64'(update_evt), 64'd1);
    checkOutput("ug_ccr1_xfer", 64'(ccr_active[31:16]), 64'h55);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'd0, '0);
      checkOutput("ug_single", 64'(update_evt), 64'd0);
      checkOutput("ug_cnt_hold", 64'(cnt_value), 64'd0);
    end

    // Asynchronous reset mid-count
    doReset();
    applyStimulus(1'b1, 4'd2, 16'd50);
    applyStimulus(1'b1, 4'd4, 16'd7);
    applyStimulus(1'b1, 4'd3, 16'h1);
    applyStimulus(1'b1, 4'd0, 16'h1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 4'd0, '0);
    checkOutput("mid_cnt", 64'(cnt_value), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_cnt", 64'(cnt_value), 64'd0);
    checkOutput("arst_ccr", 64'(ccr_active), 64'd0);
    checkOutput("arst_chen", 64'(ch_en), 64'd0);
    checkOutput("arst_upd", 64'(update_evt), 64'd0);
    checkOutput("arst_dir", 64'(cnt_dir), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 4'd0, '0);
      checkOutput("post_rst_upd", 64'(update_evt), 64'd0);
      checkOutput("post_rst_cnt", 64'(cnt_value), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_timer_ctrl.md
PWM_TIMER_CTRL -- requirements
Module: pwm_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the counter, compare and reload width.
REQ-002 SHALL have parameter NCH, default 4, the number of compare channels driven.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_wr  input  1  register write strobe, one write per asserted cycle.
REQ-007 cfg_addr  input  4  register address.
REQ-008 cfg_wdata  input  WIDTH  write data.
REQ-009 cnt_value  output  WIDTH  timer counter, fed to every channel comparator.
REQ-010 ccr_active  output  NCH*WIDTH  active compare values, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 ch_en  output  NCH  active per-channel enables.
REQ-012 update_evt  output  1  one-cycle pulse on every update event.
REQ-013 cnt_dir  output  1  0 = counting up, 1 = counting down.

Function
REQ-014 Register map SHALL be: 0 CTRL, 1 PSC, 2 ARR, 3 CCER (bits [NCH-1:0]), 4..4+NCH-1 CCR0..CCR(NCH-1); writes to other addresses are ignored.
REQ-015 CTRL bits SHALL be: bit0 CEN (count enable), bit1 CMS (0 edge-aligned, 1 center-aligned), bit2 PRE (preload enable), bit3 UG (self-clearing force update, never stored).
REQ-016 PSC, ARR, CCER and CCRx writes SHALL land in preload registers; with PRE=0 they SHALL also land in the active registers on the same edge.
REQ-017 Prescaler SHALL count 0..PSC_active while CEN=1 and issue a tick when it equals PSC_active, then return to 0; PSC=0 gives a tick every cycle.
REQ-018 Counter SHALL advance only on a tick; CEN=0 SHALL freeze the prescaler, counter and direction.
REQ-019 Edge-aligned: counter SHALL count 0..ARR_active up, wrap from ARR_active to 0, and raise an update event on that wrap.
REQ-020 Center-aligned: counter SHALL count up to ARR_active, set cnt_dir=1, count down to 0, set cnt_dir=0; update event SHALL occur only on the tick that reaches 0 while counting down.
REQ-021 ARR_active=0 SHALL hold the counter at 0 with cnt_dir=0 and raise an update event on every tick.
REQ-022 On an update event, PSC, ARR, CCER and CCRx preload values SHALL be copied to active registers, taking effect on the following cycle.
REQ-023 update_evt SHALL assert the cycle after the edge that performs the transfer, for exactly one cycle.
REQ-024 A write coinciding with an update event SHALL update only the preload register; the transfer SHALL use the pre-write preload value.
REQ-025 UG SHALL clear the prescaler and counter, set cnt_dir=0, perform the transfer and raise update_evt, regardless of CEN.
REQ-026 UG in the same cycle as a natural update event SHALL produce a single update event.
REQ-027 Changing CMS SHALL take effect at the next tick without clearing the counter; if cnt_value > ARR_active, the next tick SHALL wrap to 0 (edge) or start counting down (center).

Reset
REQ-028 On rst_n low all state SHALL clear immediately: cnt_value=0, ccr_active=0, ch_en=0, update_evt=0, cnt_dir=0, CTRL=0, PSC=0, ARR preload/active=all-ones, CCR/CCER preload=0.
REQ-029 Reset release mid-period SHALL resume counting only once CEN is written 1.

Structure
REQ-030 Register addresses, CTRL bit positions and mode encodings SHALL reside in shared package pwm_pkg.
REQ-031 Prescaler SHALL be a sub-module pwm_prescaler (inputs enable, clear, psc; output tick).
REQ-032 Channel comparators SHALL remain outside this block.

Verification
REQ-033 PRE=0, PSC=0, ARR=4, CEN=1 edge mode -> cnt 0,1,2,3,4,0; update_evt one cycle after each 4->0 wrap.
REQ-034 PSC=2, ARR=3 edge -> counter advances every 3rd cycle; one update event per 12 cycles.
REQ-035 Center mode ARR=3 -> cnt 0,1,2,3,2,1,0,1; cnt_dir 1 from the 3 until 0; update_evt only after reaching 0.
REQ-036 PRE=1, CCR0=10 written mid-period -> ccr_active[0] unchanged until the next update event, then 10.
REQ-037 UG with CEN=0 and counter=7 -> counter 0, preload transferred, single update_evt pulse.
REQ-038 rst_n asserted mid-count -> all outputs at reset values immediately, no update_evt after release.
